// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 16-bit accumulator CPU.
// Owns the program counter and emits one-cycle Moore load strobes and ALU controls.
module cpu_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_load,
  output logic              dr_load,
  output logic [12:0]       imm,
  output logic [2:0]        alu_op,
  output logic              alu_sub,
  output logic              acc_load,
  output logic              acc_sel,
  output logic              out_load,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0]        OP_LDI = 3'b101;
  localparam logic [2:0]        OP_JMP = 3'b110;
  localparam logic [2:0]        OP_HLT = 3'b111;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  // Opcode to {alu_sub, alu_op}; LDI/JMP/HLT drive a neutral zero.
  function automatic logic [3:0] alu_decode(input logic [2:0] op);
    logic [3:0] r;
    case (op)
      3'b000:  r = 4'b0000;
      3'b001:  r = 4'b1000;
      3'b010:  r = 4'b0010;
      3'b011:  r = 4'b0011;
      3'b100:  r = 4'b0100;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  state_t            state_r, state_next_s;
  logic [DATA_W-1:0] ir_r, ir_next_s;
  logic [ADDR_W-1:0] pc_r, pc_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic [2:0]        op_s, op_next_s;
  logic [3:0]        alu_dec_s;
  logic              ir_load_s, dr_load_s, alu_sub_s, acc_load_s, acc_sel_s;
  logic              out_load_s, busy_s, halted_s;
  logic [2:0]        alu_op_s;

  assign op_s = ir_r[DATA_W-1 -: 3];

  // Next state, program counter, instruction register and retired counter.
  always_comb begin
    state_next_s = state_r;
    ir_next_s    = ir_r;
    pc_next_s    = pc_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_next_s = S_FETCH;
          pc_next_s    = '0;
          cnt_next_s   = '0;
        end else begin
          state_next_s = state_r;
        end
      end
      S_FETCH: begin
        state_next_s = S_DECODE;
        ir_next_s    = instr;
      end
      S_DECODE: begin
        if (op_s == OP_HLT) begin
          state_next_s = S_HALT;
        end else begin
          state_next_s = S_EXEC;
        end
      end
      S_EXEC: state_next_s = S_WB;
      S_WB: begin
        state_next_s = S_FETCH;
        if (op_s == OP_JMP) begin
          pc_next_s = ir_r[ADDR_W-1:0];
        end else begin
          pc_next_s = pc_r + PC_ONE;
        end
        if (&cnt_r) begin
          cnt_next_s = cnt_r;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Outputs for the state being entered, so they can be registered yet stay Moore.
  always_comb begin
    op_next_s  = ir_next_s[DATA_W-1 -: 3];
    alu_dec_s  = alu_decode(op_next_s);
    ir_load_s  = 1'b0;
    dr_load_s  = 1'b0;
    alu_op_s   = 3'b000;
    alu_sub_s  = 1'b0;
    acc_load_s = 1'b0;
    acc_sel_s  = 1'b0;
    out_load_s = 1'b0;
    busy_s     = 1'b0;
    halted_s   = 1'b0;
    case (state_next_s)
      S_FETCH: begin
        ir_load_s = 1'b1;
        busy_s    = 1'b1;
      end
      S_DECODE: begin
        busy_s = 1'b1;
        if (op_next_s != OP_HLT) begin
          dr_load_s = 1'b1;
        end else begin
          dr_load_s = 1'b0;
        end
      end
      S_EXEC: begin
        busy_s    = 1'b1;
        alu_op_s  = alu_dec_s[2:0];
        alu_sub_s = alu_dec_s[3];
      end
      S_WB: begin
        busy_s    = 1'b1;
        alu_op_s  = alu_dec_s[2:0];
        alu_sub_s = alu_dec_s[3];
        if (op_next_s != OP_JMP) begin
          acc_load_s = 1'b1;
          out_load_s = 1'b1;
          acc_sel_s  = (op_next_s == OP_LDI);
        end else begin
          acc_load_s = 1'b0;
          out_load_s = 1'b0;
          acc_sel_s  = 1'b0;
        end
      end
      S_HALT:  halted_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath-facing registers and registered strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_r     <= '0;
      pc_r     <= '0;
      cnt_r    <= '0;
      ir_load  <= 1'b0;
      dr_load  <= 1'b0;
      alu_op   <= 3'b000;
      alu_sub  <= 1'b0;
      acc_load <= 1'b0;
      acc_sel  <= 1'b0;
      out_load <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      ir_r     <= ir_next_s;
      pc_r     <= pc_next_s;
      cnt_r    <= cnt_next_s;
      ir_load  <= ir_load_s;
      dr_load  <= dr_load_s;
      alu_op   <= alu_op_s;
      alu_sub  <= alu_sub_s;
      acc_load <= acc_load_s;
      acc_sel  <= acc_sel_s;
      out_load <= out_load_s;
      busy     <= busy_s;
      halted   <= halted_s;
    end
  end

  assign pc          = pc_r;
  assign imm         = ir_r[12:0];
  assign instr_count = cnt_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed, table-driven bench for cpu_sequencer: per-cycle expected outputs for
// small programs, plus hand sequences for reset-in-flight and counter saturation.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start2;
  logic [15:0] mem  [16];
  logic [15:0] mem2 [16];

  logic [15:0] instr;
  logic [3:0]  pc;
  logic        ir_load, dr_load, alu_sub, acc_load, acc_sel, out_load, busy, halted;
  logic [12:0] imm;
  logic [2:0]  alu_op;
  logic [7:0]  instr_count;

  logic [15:0] instr2;
  logic [3:0]  pc2;
  logic        ir_load2, dr_load2, alu_sub2, acc_load2, acc_sel2, out_load2, busy2, halted2;
  logic [12:0] imm2;
  logic [2:0]  alu_op2;
  logic [1:0]  cnt2;

  assign instr  = mem[pc];
  assign instr2 = mem2[pc2];

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .pc(pc),
    .ir_load(ir_load), .dr_load(dr_load), .imm(imm), .alu_op(alu_op),
    .alu_sub(alu_sub), .acc_load(acc_load), .acc_sel(acc_sel),
    .out_load(out_load), .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  cpu_sequencer #(.ADDR_W(4), .DATA_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .instr(instr2), .pc(pc2),
    .ir_load(ir_load2), .dr_load(dr_load2), .imm(imm2), .alu_op(alu_op2),
    .alu_sub(alu_sub2), .acc_load(acc_load2), .acc_sel(acc_sel2),
    .out_load(out_load2), .busy(busy2), .halted(halted2), .instr_count(cnt2)
  );

  logic [35:0] act;
  assign act = {ir_load, dr_load, alu_op, alu_sub, acc_load, acc_sel, out_load,
                busy, halted, pc, imm, instr_count};

  typedef struct {
    logic        start;
    logic [35:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [35:0] ex(input int ir, input int dr, input int op, input int sub,
                                     input int al, input int as, input int ol, input int bz,
                                     input int hl, input int p, input int im, input int c);
    return {1'(ir), 1'(dr), 3'(op), 1'(sub), 1'(al), 1'(as), 1'(ol), 1'(bz), 1'(hl),
            4'(p), 13'(im), 8'(c)};
  endfunction

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick(input logic s);
    start = s;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic add(input logic s, input logic [35:0] e);
    vecs.push_back('{start: s, exp: e});
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      tick(vecs[i].start);
      check($sformatf("%s_v%0d", tag, i), act, vecs[i].exp);
    end
    vecs.delete();
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 16'hE000;
      mem2[i] = 16'hE000;
    end
    mem[0] = 16'hA005;
    mem[1] = 16'h0003;
    mem[2] = 16'hE000;
    for (int i = 0; i < 5; i++) mem2[i] = 16'hA000 | 16'(i + 1);
    mem2[5] = 16'hE000;

    @(negedge clk);
    tick(1'b1);
    tick(1'b0);
    check("reset_state", act, 36'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      check($sformatf("idle%0d", i), act, 36'd0);
    end

    // LDI 5 / ADD 3 / HLT
    add(1'b1, ex(1,0,0,0,0,0,0,1,0,0,0,0));
    add(1'b0, ex(0,1,0,0,0,0,0,1,0,0,5,0));
    add(1'b0, ex(0,0,0,0,0,0,0,1,0,0,5,0));
    add(1'b0, ex(0,0,0,0,1,1,1,1,0,0,5,0));
    add(1'b0, ex(1,0,0,0,0,0,0,1,0,1,5,1));
    add(1'b0, ex(0,1,0,0,0,0,0,1,0,1,3,1));
    add(1'b0, ex(0,0,0,0,0,0,0,1,0,1,3,1));
    add(1'b0, ex(0,0,0,0,1,0,1,1,0,1,3,1));
    add(1'b0, ex(1,0,0,0,0,0,0,1,0,2,3,2));
    add(1'b0, ex(0,0,0,0,0,0,0,1,0,2,0,2));
    add(1'b0, ex(0,0,0,0,0,0,0,0,1,2,0,2));
    add(1'b0, ex(0,0,0,0,0,0,0,0,1,2,0,2));
    run_table("seq");

    // SUB 1 / JMP 15 / XOR 7 at 15 / wrap to 0; restart from HALT, start ignored while busy
    mem[0]  = 16'h2001;
    mem[1]  = 16'hC00F;
    mem[15] = 16'h8007;
    add(1'b1, ex(1,0,0,0,0,0,0,1,0,0,0,0));
    add(1'b0, ex(0,1,0,0,0,0,0,1,0,0,1,0));
    add(1'b0, ex(0,0,0,1,0,0,0,1,0,0,1,0));
    add(1'b1, ex(0,0,0,1,1,0,1,1,0,0,1,0));
    add(1'b0, ex(1,0,0,0,0,0,0,1,0,1,1,1));
    add(1'b0, ex(0,1,0,0,0,0,0,1,0,1,15,1));
    add(1'b1, ex(0,0,0,0,0,0,0,1,0,1,15,1));
    add(1'b1, ex(0,0,0,0,0,0,0,1,0,1,15,1));
    add(1'b0, ex(1,0,0,0,0,0,0,1,0,15,15,2));
    add(1'b0, ex(0,1,0,0,0,0,0,1,0,15,7,2));
    add(1'b0, ex(0,0,4,0,0,0,0,1,0,15,7,2));
    add(1'b0, ex(0,0,4,0,1,0,1,1,0,15,7,2));
    add(1'b0, ex(1,0,0,0,0,0,0,1,0,0,7,3));
    add(1'b0, ex(0,1,0,0,0,0,0,1,0,0,1,3));
    add(1'b0, ex(0,0,0,1,0,0,0,1,0,0,1,3));
    add(1'b0, ex(0,0,0,1,1,0,1,1,0,0,1,3));
    run_table("jmp");

    // Reset asserted while in WB: nothing may fire afterwards
    reset = 1'b0;
    tick(1'b0);
    check("reset_mid_wb", act, 36'd0);
    reset = 1'b1;
    tick(1'b0);
    check("idle_after_reset", act, 36'd0);

    // Saturating counter on the CNT_W=2 instance: five LDIs then HLT
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    check("sat_fetch0", {34'd0, cnt2}, 36'd0);
    for (int k = 1; k <= 5; k++) begin
      repeat (4) tick(1'b0);
      check($sformatf("sat_fetch%0d", k), {34'd0, cnt2}, 36'(k > 3 ? 3 : k));
    end
    repeat (2) tick(1'b0);
    check("sat_halted", {34'd0, halted2, cnt2}, {34'd0, 1'b1, 2'd3});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit accumulator CPU. It replaces the fixed instruction-memory address and free-running register loads with a program counter and a FETCH/DECODE/EXEC/WB state machine. It emits the load strobes for the instruction, data, accumulator and output registers, plus the ALU opcode and subtract controls. It sits between the instruction memory and the existing register/ALU datapath, and owns program flow (sequential, jump, halt).

## Interface
- ADDR_W, 4, program counter / instruction-memory address width
- DATA_W, 16, instruction width
- CNT_W, 8, retired-instruction counter width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse; begins execution at address 0 when IDLE or HALT
- instr  in  DATA_W  instruction-memory read data, combinational from pc
- pc  out  ADDR_W  instruction-memory address
- ir_load  out  1  instruction register load strobe
- dr_load  out  1  data register load strobe (data register takes imm)
- imm  out  13  latched instr[12:0]
- alu_op  out  3  ALU op_select
- alu_sub  out  1  ALU subtract control
- acc_load  out  1  accumulator load strobe
- acc_sel  out  1  accumulator source: 0 = ALU result, 1 = imm (zero-extended)
- out_load  out  1  output register load strobe
- busy  out  1  high in FETCH, DECODE, EXEC and WB
- halted  out  1  high in HALT
- instr_count  out  CNT_W  retired instructions since last start, saturating

## Operation
- Instruction format: [15:13] opcode, [12:0] immediate.
- Opcodes:
  - 000 ADD (alu_op 000, sub 0)
  - 001 SUB (alu_op 000, sub 1)
  - 010 AND (alu_op 010)
  - 011 OR (alu_op 011)
  - 100 XOR (alu_op 100)
  - 101 LDI
  - 110 JMP
  - 111 HLT
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: start=1 -> FETCH, pc<=0, instr_count<=0. Otherwise stay.
- FETCH: ir_load=1. Internal IR <= instr at the clock edge. -> DECODE.
- DECODE:
  - opcode 111 -> HALT. No dr_load, no pc change, no count.
  - Otherwise dr_load=1 -> EXEC.
- EXEC: alu_op/alu_sub driven from latched opcode (0 for LDI/JMP). -> WB.
- WB actions by opcode:
  - ALU ops: acc_load=1, acc_sel=0, out_load=1, pc<=pc+1.
  - LDI: acc_load=1, acc_sel=1, out_load=1, pc<=pc+1.
  - JMP: no loads, pc<=imm[ADDR_W-1:0].
- WB (all opcodes): instr_count<=instr_count+1, saturating at 2^CNT_W-1. -> FETCH.
- HALT: halted=1, pc frozen. start=1 -> FETCH with pc<=0, instr_count<=0.
- pc increment wraps modulo 2^ADDR_W (15 -> 0 for default).
- start in FETCH/DECODE/EXEC/WB is ignored; the current program is not restarted.
- Strobe width: every strobe is exactly one cycle wide and depends only on state and latched IR (Moore).
- Hold rules:
  - alu_op/alu_sub hold the latched opcode decode in EXEC and WB; 0 elsewhere.
  - imm holds the IR value until the next FETCH edge.

## Timing
- Reset (reset=0 at rising edge): state IDLE, pc=0, internal IR=0, instr_count=0. Every output is 0, including imm, alu_op, busy and halted. Reset overrides start and any in-flight instruction; no strobe fires in the reset cycle's next state.
- Instruction latency: 4 cycles (FETCH, DECODE, EXEC, WB); throughput 1 instruction per 4 cycles.
- HLT takes 2 cycles (FETCH, DECODE); halted rises on the 3rd cycle.
- start sampled in IDLE at edge N: FETCH is active in cycle N+1, with pc=0 and busy=1.
- The accumulator load from the ALU result happens at the end of WB; that result is combinational from the data loaded at the end of DECODE.
- instr updates the IR only on the FETCH edge; instr changes in other states have no effect.

## Test plan
- Reset/idle: hold reset=0 for 2 cycles, release, no start for 10 cycles -> all outputs 0, state IDLE, pc=0.
- Sequential ALU program: mem[0]=LDI 5 (0xA005), mem[1]=ADD 3 (0x0003), mem[2]=HLT (0xE000); pulse start -> ir_load at cycles 1, 5, 9; acc_load with acc_sel=1 at cycle 4, acc_sel=0 with alu_op=000 alu_sub=0 at cycle 8; halted=1 from cycle 11; instr_count=2; pc=2.
- SUB/jump/wrap: mem[0]=SUB 1 (0x2001), mem[1]=JMP 15 (0xC00F), mem[15]=XOR 7 (0x8007), mem[0] re-fetched -> alu_sub=1 in EXEC/WB of the first instruction; pc=15 after the JMP WB; pc wraps 15->0 after the XOR WB; no acc_load/out_load during JMP.
- Ignored start and restart: pulse start mid-EXEC -> no effect on pc or state. After HLT, pulse start -> FETCH next cycle with pc=0 and instr_count=0.
- Reset mid-operation: assert reset=0 during a WB cycle -> no acc_load/out_load on the following cycle, state IDLE, pc=0, instr_count=0.
- Counter saturation (CNT_W=2): program of 5 LDIs then HLT -> instr_count reads 3, 3 after the 4th and 5th instructions.
